// File: rtl/seq_game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_game_pkg
// Description : Shared types and constants for the colour-sequence game.
//               Holds the display-player state enum, the default LED/ROM word
//               width, the blank LED bit and a small integer max helper.
//               Also used by the input-compare stage.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_game_pkg;

  localparam int P_DATA_DEF = 4;

  // One bit of a blank LED vector; replicate to the vector width at use sites.
  localparam logic LED_BLANK = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_FETCH = 3'd2,
    ST_SHOW  = 3'd3,
    ST_GAP   = 3'd4,
    ST_ADV   = 3'd5,
    ST_CHECK = 3'd6,
    ST_DONE  = 3'd7
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_display_player_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_display_player_if
// Description : Bus between the sequence player and the round address
//               counter / sequence ROM.
//   cnt_R    : active-high counter reset pulse        (player -> counter)
//   cnt_E    : 1-cycle counter increment pulse        (player -> counter)
//   cnt_tc   : sticky terminal carry                  (counter -> player)
//   rom_data : ROM word at the counter address        (ROM -> player)
// Modports    : master = player side, slave = counter/ROM side
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_display_player_if #(
  parameter int P_DATA = 4
);
  logic              cnt_R;
  logic              cnt_E;
  logic              cnt_tc;
  logic [P_DATA-1:0] rom_data;

  modport master (output cnt_R, output cnt_E, input cnt_tc, input rom_data);
  modport slave  (input cnt_R, input cnt_E, output cnt_tc, output rom_data);
endinterface
`default_nettype wire

// File: rtl/seq_display_player_dwell_timer.sv
`default_nettype none
// ============================================================================
// Module      : dwell_timer
// Description : Tick-gated up-counter with synchronous clear. term is high
//               on the tick that completes 'limit' counted ticks.
//   clk   in   system clock
//   R     in   synchronous active-low reset
//   clr   in   clear count to 0 (wins over tick)
//   tick  in   count enable
//   limit in   number of ticks to count (>=1), selected at runtime
//   term  out  combinational: this tick is the limit-th
// Revision    : 1.0 - initial release
// ============================================================================
module dwell_timer #(
  parameter int P_W = 2
) (
  input  wire logic           clk,
  input  wire logic           R,
  input  wire logic           clr,
  input  wire logic           tick,
  input  wire logic [P_W-1:0] limit,
  output logic                term
);

  localparam logic [P_W-1:0] ONE = P_W'(1);

  logic [P_W-1:0] cnt_q;
  logic [P_W-1:0] cnt_d;

  assign term = tick && (cnt_q == (limit - ONE));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!R) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_display_player.sv
`default_nettype none
// ============================================================================
// Module      : seq_display_player
// Description : Plays the FPGA colour sequence for the current round on the
//               LEDs. Clears the round address counter, then for each
//               address shows the ROM word for P_ON_TICKS ticks, blanks for
//               P_OFF_TICKS ticks, increments the counter and stops once the
//               counter terminal carry is seen.
// Ports       :
//   clk      in   system clock
//   R        in   synchronous active-low reset
//   start    in   1-cycle request to play (ignored while busy)
//   tick     in   timebase enable; only SHOW/GAP wait on it
//   abort    in   (SEQ_PLAYER_ABORT_EN only) blank and return to IDLE
//   cnt_bus  if   counter/ROM bus (master side)
//   leds     out  displayed symbol, 0 = blank
//   busy     out  high in every state except IDLE
//   done     out  1-cycle pulse when the sequence has fully played
// Config      : SEQ_PLAYER_ABORT_EN adds the abort input.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_display_player
  import seq_game_pkg::*;
#(
  parameter int P_DATA      = P_DATA_DEF,
  parameter int P_ON_TICKS  = 50,
  parameter int P_OFF_TICKS = 25
) (
  input  wire logic               clk,
  input  wire logic               R,
  input  wire logic               start,
  input  wire logic               tick,
`ifdef SEQ_PLAYER_ABORT_EN
  input  wire logic               abort,
`endif
  seq_display_player_if.master    cnt_bus,
  output logic [P_DATA-1:0]       leds,
  output logic                    busy,
  output logic                    done
);

  localparam int DW = $clog2(max_int(P_ON_TICKS, P_OFF_TICKS) + 1);

  state_e            state_q;
  state_e            state_d;
  logic [P_DATA-1:0] word_q;
  logic [P_DATA-1:0] word_d;

  logic              dwell_clr;
  logic              dwell_term;
  logic [DW-1:0]     dwell_limit;
  logic              blank_now;

`ifdef SEQ_PLAYER_ABORT_EN
  assign blank_now = abort;
`else
  assign blank_now = 1'b0;
`endif

  // The timer holds at 0 outside SHOW/GAP and is cleared on the terminal
  // tick, so it always starts from 0 on entry to SHOW and to GAP.
  assign dwell_clr   = !((state_q == ST_SHOW) || (state_q == ST_GAP)) || dwell_term;
  assign dwell_limit = (state_q == ST_GAP) ? DW'(P_OFF_TICKS) : DW'(P_ON_TICKS);

  dwell_timer #(
    .P_W (DW)
  ) u_dwell (
    .clk   (clk),
    .R     (R),
    .clr   (dwell_clr),
    .tick  (tick),
    .limit (dwell_limit),
    .term  (dwell_term)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_CLR;
      ST_CLR:   state_d = ST_FETCH;
      ST_FETCH: begin
        // Address settled at the end of CLR/ADV; the ROM word is valid now.
        word_d  = cnt_bus.rom_data;
        state_d = ST_SHOW;
      end
      ST_SHOW:  if (dwell_term) state_d = ST_GAP;
      ST_GAP:   if (dwell_term) state_d = ST_ADV;
      ST_ADV:   state_d = ST_CHECK;
      ST_CHECK: state_d = cnt_bus.cnt_tc ? ST_DONE : ST_FETCH;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (blank_now && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!R) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
    end
  end

  // Outputs decode the state register directly so reset forces them low.
  assign cnt_bus.cnt_R = (state_q == ST_CLR);
  assign cnt_bus.cnt_E = (state_q == ST_ADV);
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign leds          = ((state_q == ST_SHOW) && !blank_now) ? word_q : {P_DATA{LED_BLANK}};

endmodule
`default_nettype wire

// File: tb/tb_seq_display_player.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_display_player
// Description : Directed self-checking bench for seq_display_player with
//               ON=3, OFF=2, a round counter model and ROM = 1,2,4,8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_display_player;

  localparam int ON  = 3;
  localparam int OFF = 2;

  logic       clk = 1'b0;
  logic       R;
  logic       start;
  logic       tick;
  logic       abort;
  logic [3:0] leds;
  logic       busy;
  logic       done;

  int n_assert = 0;
  int n_fail   = 0;

  // Counter + ROM model
  logic [7:0] round_v = 8'd0;
  logic [7:0] addr    = 8'd0;
  logic       tc      = 1'b0;
  logic [3:0] rom_w;

  seq_display_player_if #(.P_DATA(4)) bus ();

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.cnt_R) begin
      addr <= 8'd0;
      tc   <= 1'b0;
    end else if (bus.cnt_E) begin
      if (addr == round_v) tc <= 1'b1;
      addr <= addr + 8'd1;
    end
  end

  always_comb rom_w = 4'b0001 << addr[1:0];
  assign bus.cnt_tc   = tc;
  assign bus.rom_data = rom_w;

  seq_display_player #(
    .P_DATA      (4),
    .P_ON_TICKS  (ON),
    .P_OFF_TICKS (OFF)
  ) dut (
    .clk     (clk),
    .R       (R),
    .start   (start),
    .tick    (tick),
`ifdef SEQ_PLAYER_ABORT_EN
    .abort   (abort),
`endif
    .cnt_bus (bus),
    .leds    (leds),
    .busy    (busy),
    .done    (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected behaviour with tick=1: cycle 1 = CLR, then 8 cycles per symbol
  // (FETCH, 3x SHOW, 2x GAP, ADV, CHECK), DONE at cycle 2+8*(r+1).
  function automatic logic [3:0] m_leds(input int c, input int r);
    int k, p;
    if (c < 2) return 4'd0;
    k = (c - 2) / 8;
    p = (c - 2) % 8;
    if (k > r) return 4'd0;
    if (p >= 1 && p <= 3) return 4'(1 << k);
    return 4'd0;
  endfunction

  function automatic logic m_e(input int c, input int r);
    if (c < 2) return 1'b0;
    return ((c - 2) / 8 <= r) && ((c - 2) % 8 == 6);
  endfunction

  // Plays round r from IDLE and checks every cycle against the model.
  // start is re-pulsed in cycle inj (0 = never); it must have no effect.
  task automatic run_check(input int r, input int inj);
    int d;
    d = 2 + 8 * (r + 1);
    round_v = 8'(r);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= d + 2; c++) begin
      chk($sformatf("r%0d_leds_c%0d", r, c), 32'(leds), 32'(m_leds(c, r)));
      chk($sformatf("r%0d_cntE_c%0d", r, c), 32'(bus.cnt_E), 32'(m_e(c, r)));
      chk($sformatf("r%0d_cntR_c%0d", r, c), 32'(bus.cnt_R), 32'(c == 1));
      chk($sformatf("r%0d_done_c%0d", r, c), 32'(done), 32'(c == d));
      chk($sformatf("r%0d_busy_c%0d", r, c), 32'(busy), 32'(c <= d));
      start = (c == inj);
      step();
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lit, done_c, dones;
    R = 1'b0; start = 1'b0; tick = 1'b1; abort = 1'b0;
    step(); step(); step();
    chk("rst_leds", 32'(leds), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cntR", 32'(bus.cnt_R), 32'd0);
    chk("rst_cntE", 32'(bus.cnt_E), 32'd0);
    R = 1'b1;
    step();

    // Single symbol, then four symbols 1,2,4,8
    run_check(0, 0);
    run_check(3, 0);
    // start during SHOW of the first symbol is ignored
    run_check(1, 4);
    // start in the DONE cycle is dropped
    run_check(2, 26);

    // tick low for 5 cycles during SHOW stretches the symbol to 8 cycles
    round_v = 8'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    lit = 0; done_c = 0;
    for (int c = 1; c <= 25; c++) begin
      if (leds == 4'd1) lit++;
      if (done && done_c == 0) done_c = c;
      if (c == 11 || c == 12) chk($sformatf("tick_gap_leds_c%0d", c), 32'(leds), 32'd0);
      if (c == 13) chk("tick_cntE_c13", 32'(bus.cnt_E), 32'd1);
      tick = !(c >= 4 && c <= 8);
      step();
    end
    tick = 1'b1;
    chk("tick_lit_cycles", 32'(lit), 32'd8);
    chk("tick_done_cycle", 32'(done_c), 32'd15);

    // Reset during GAP of symbol 2 (cycle 22)
    round_v = 8'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 22; c++) step();
    chk("rstmid_gap_busy", 32'(busy), 32'd1);
    chk("rstmid_gap_leds", 32'(leds), 32'd0);
    R = 1'b0;
    step();
    R = 1'b1;
    chk("rstmid_leds", 32'(leds), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (done || busy) dones++;
      step();
    end
    chk("rstmid_idle_after", 32'(dones), 32'd0);
    run_check(1, 0);

`ifdef SEQ_PLAYER_ABORT_EN
    round_v = 8'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 4; c++) step();
    chk("abort_pre_leds", 32'(leds), 32'd1);
    abort = 1'b1;
    #1;
    chk("abort_same_cycle_leds", 32'(leds), 32'd0);
    step();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_leds", 32'(leds), 32'd0);
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) dones++;
      step();
    end
    chk("abort_no_done", 32'(dones), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
